bsg_upstream_io_tx: RTL and testbench

Transmit end of the off-chip byte link. Takes 32-bit words from the core side and serializes each into four 8-bit IO beats, low byte first. These are the words that the downstream receiver reassembles into core_data_out. Flow control is credit-based: the remote receiver returns one io_token_in pulse per word it consumes. The block sits between the core-side producer and the IO pad logic, in the clk domain.

---
 rtl/bsg_link_pkg.sv | 48 ++++
 rtl/bsg_link_credit_cnt.sv | 49 ++++
 rtl/bsg_upstream_io_tx.sv | 102 ++++++++++
 tb/tb_bsg_upstream_io_tx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bsg_link_pkg.sv
// Shared definitions for the off-chip byte link (transmit and receive ends).
// Optional feature macro: BSG_UPSTREAM_TX_PARITY_EN
//   When defined, each 32-bit word is followed by a fifth beat carrying the
//   XOR of its four data bytes, and the beat counter widens to 3 bits.
package bsg_link_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;

`ifdef BSG_UPSTREAM_TX_PARITY_EN
  localparam int unsigned BEATS_PER_WORD = 5;
  localparam int unsigned BEAT_W         = 3;
`else
  localparam int unsigned BEATS_PER_WORD = 4;
  localparam int unsigned BEAT_W         = 2;
`endif

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_WORD - 1);

  localparam int unsigned DEFAULT_CREDITS = 16;
  localparam int unsigned DEFAULT_CW      = 7;

  // Byte carried on the wire for a given beat of a word.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [BEAT_W-1:0] beat);
    logic [WORD_W-1:0] shifted;
`ifdef BSG_UPSTREAM_TX_PARITY_EN
    logic [BYTE_W-1:0] par;
    if (beat == LAST_BEAT) begin
      par = '0;
      for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
        shifted = w >> (BYTE_W * i);
        par     = par ^ shifted[BYTE_W-1:0];
      end
      return par;
    end
`endif
    shifted = w >> (BYTE_W * int'(beat));
    return shifted[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/bsg_link_credit_cnt.sv
// Saturating up/down credit counter with a sticky overflow flag.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (count returns to MAX)
//   inc        - one-cycle pulse returning a credit
//   dec        - consume a credit (caller guarantees count != 0)
//   count      - registered credit count
//   overflow   - sticky flag, set when a credit returns while already at MAX
module bsg_link_credit_cnt #(
  parameter int unsigned MAX = 16,
  parameter int unsigned W   = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);

  logic [W-1:0] count_d;
  logic         overflow_d;

  // Simultaneous inc and dec cancel; inc at MAX saturates and flags.
  always_comb begin
    count_d    = count;
    overflow_d = overflow;
    unique case ({inc, dec})
      2'b10: begin
        if (count == W'(MAX)) overflow_d = 1'b1;
        else                  count_d    = count + W'(1);
      end
      2'b01: begin
        if (count != '0) count_d = count - W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= W'(MAX);
      overflow <= 1'b0;
    end else begin
      count    <= count_d;
      overflow <= overflow_d;
    end
  end

endmodule

// File: rtl/bsg_upstream_io_tx.sv
// Transmit end of the off-chip byte link: serializes 32-bit core words into
// 8-bit IO beats, low byte first, under credit-based flow control.
// Optional feature macro: BSG_UPSTREAM_TX_PARITY_EN (adds an XOR parity beat).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   core_data_in    - word to send
//   core_valid_in   - core_data_in is valid
//   core_ready_out  - word accepted this cycle if valid (combinational)
//   io_data_out     - IO byte (registered)
//   io_valid_out    - io_data_out valid (registered)
//   io_token_in     - one-cycle pulse returning one word credit
//   credits         - available credits (registered)
//   credit_overflow - sticky credit overflow flag (registered)
module bsg_upstream_io_tx
  import bsg_link_pkg::*;
#(
  parameter int unsigned CREDITS = DEFAULT_CREDITS,
  parameter int unsigned CW      = DEFAULT_CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] core_data_in,
  input  logic              core_valid_in,
  output logic              core_ready_out,
  output logic [BYTE_W-1:0] io_data_out,
  output logic              io_valid_out,
  input  logic              io_token_in,
  output logic [CW-1:0]     credits,
  output logic              credit_overflow
);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   io_data_d;
  logic                io_valid_d;
  logic                accept;

  // Ready uses the registered credit count, so a token arriving while empty
  // only enables acceptance on the following cycle.
  assign core_ready_out = (credits != '0) &&
                          ((state_q == IDLE) || ((state_q == SEND) && (beat_q == LAST_BEAT)));
  assign accept = core_valid_in && core_ready_out;

  bsg_link_credit_cnt #(
    .MAX (CREDITS),
    .W   (CW)
  ) u_credit_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (io_token_in),
    .dec      (accept),
    .count    (credits),
    .overflow (credit_overflow)
  );

  // Next-state, next-beat and the IO byte for the upcoming cycle.
  // The IO registers are loaded from the next state so that byte0 appears
  // the cycle right after acceptance.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    shift_d    = shift_q;
    io_valid_d = 1'b0;
    io_data_d  = '0;

    if (accept) begin
      shift_d = core_data_in;
      state_d = SEND;
      beat_d  = '0;
    end else if (state_q == SEND) begin
      if (beat_q == LAST_BEAT) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end

    if (state_d == SEND) begin
      io_valid_d = 1'b1;
      io_data_d  = word_byte(shift_d, beat_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      shift_q      <= '0;
      io_data_out  <= '0;
      io_valid_out <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      shift_q      <= shift_d;
      io_data_out  <= io_data_d;
      io_valid_out <= io_valid_d;
    end
  end

endmodule

// File: tb/tb_bsg_upstream_io_tx.sv
// Self-checking bench for bsg_upstream_io_tx. The reference model tracks the
// queue of bytes still owed to the wire and a credit count.
module tb_bsg_upstream_io_tx;

  localparam int unsigned CREDITS = 16;
  localparam int unsigned CW      = 7;
`ifdef BSG_UPSTREAM_TX_PARITY_EN
  localparam int unsigned NBEATS = 5;
`else
  localparam int unsigned NBEATS = 4;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   core_data_in = '0;
  logic          core_valid_in = 1'b0;
  logic          core_ready_out;
  logic [7:0]    io_data_out;
  logic          io_valid_out;
  logic          io_token_in = 1'b0;
  logic [CW-1:0] credits;
  logic          credit_overflow;

  bsg_upstream_io_tx #(.CREDITS(CREDITS), .CW(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .core_data_in    (core_data_in),
    .core_valid_in   (core_valid_in),
    .core_ready_out  (core_ready_out),
    .io_data_out     (io_data_out),
    .io_valid_out    (io_valid_out),
    .io_token_in     (io_token_in),
    .credits         (credits),
    .credit_overflow (credit_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [7:0] m_q[$];
  int         m_cred = CREDITS;
  bit         m_ovf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Ready: a credit is available and at most the final beat of a word is
  // still owed to the wire.
  function automatic bit m_ready();
    return (m_cred != 0) && (m_q.size() <= 1);
  endfunction

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic step(input bit v, input logic [31:0] d, input bit t, input bit r, input bit chk);
    bit   acc;
    logic [7:0] par;
    @(negedge clk);
    core_valid_in = v;
    core_data_in  = d;
    io_token_in   = t;
    rst           = r;
    #1;
    if (chk) begin
      check("ready", 32'(core_ready_out), 32'(m_ready()));
      check("io_valid", 32'(io_valid_out), 32'(m_q.size() > 0));
      if (m_q.size() > 0) check("io_data", 32'(io_data_out), 32'(m_q[0]));
      check("credits", 32'(credits), 32'(m_cred));
      check("overflow", 32'(credit_overflow), 32'(m_ovf));
    end
    if (r) begin
      m_q.delete();
      m_cred = CREDITS;
      m_ovf  = 1'b0;
    end else begin
      acc = v && m_ready();
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (acc) begin
        par = '0;
        for (int i = 0; i < 4; i++) begin
          m_q.push_back(d[8*i +: 8]);
          par = par ^ d[8*i +: 8];
        end
        if (NBEATS == 5) m_q.push_back(par);
      end
      if (acc && !t)      m_cred--;
      else if (t && !acc) begin
        if (m_cred == CREDITS) m_ovf = 1'b1;
        else                   m_cred++;
      end
    end
  endtask

  // Hold a word valid until the model says it is accepted (bounded).
  task automatic send_word(input logic [31:0] d, input bit t);
    bit rdy;
    for (int k = 0; k < 20; k++) begin
      rdy = m_ready();
      step(1'b1, d, rdy ? t : 1'b0, 1'b0, 1'b1);
      if (rdy) return;
    end
    check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, $urandom, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    // Initial reset; outputs are unknown before the first edge.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Single word, low byte first.
    send_word(32'hA1B2C3D4, 1'b0);
    idle(6);

    // Two words back to back give contiguous beats.
    send_word(32'h0000_0001, 1'b0);
    send_word(32'hFFFF_0000, 1'b0);
    idle(6);

    // Drain all credits, then return one.
    do_reset();
    for (int i = 0; i < 16; i++) send_word($urandom, 1'b0);
    idle(6);
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
    send_word(32'h1234_5678, 1'b0);
    idle(6);

    // Accept and token together at credits == 5.
    do_reset();
    for (int i = 0; i < 11; i++) send_word($urandom, 1'b0);
    send_word(32'hCAFE_F00D, 1'b1);
    idle(6);

    // Token with full credits sets the sticky overflow flag.
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(3);
    send_word(32'h0BAD_BEEF, 1'b1);
    idle(6);

    // Reset during beat 2, then a fresh word.
    do_reset();
    send_word(32'h5566_7788, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    send_word(32'hA1B2C3D4, 1'b0);
    idle(6);

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'b1 & ($urandom_range(0, 3) != 0), $urandom,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 199) == 0), 1'b1);
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
